mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 106 ++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port: instruction fetch and load/store share one
// single-ported memory, round-robin arbitrated, one access in flight at a time.
module mem_port_arbiter #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_done,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t     state, state_nxt;
  logic       owner_ls, last_ls, we_q;
  logic       grant, pick_ls;
  logic [2:0] cnt;

  // Grant is combinational in IDLE so it lands in the request's own cycle;
  // gated by reset so nothing is accepted while reset is held.
  assign grant   = reset && (state == IDLE) && (if_req || ls_req);
  assign pick_ls = ls_req && !(if_req && last_ls);

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (cnt == 3'd0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    if_gnt  = grant && !pick_ls;
    ls_gnt  = grant && pick_ls;
    mem_en  = (state == ISSUE);
    mem_we  = (state == ISSUE) && we_q;
    if_done = (state == DONE) && !owner_ls;
    ls_done = (state == DONE) && owner_ls;
    busy    = (state != IDLE);
  end

  // Request fields are latched at grant so later input changes cannot
  // disturb the access in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      owner_ls  <= 1'b0;
      last_ls   <= 1'b0;
      we_q      <= 1'b0;
      cnt       <= 3'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
    end else begin
      case (state)
        IDLE: if (grant) begin
          owner_ls  <= pick_ls;
          last_ls   <= pick_ls;
          we_q      <= pick_ls && ls_we;
          mem_addr  <= pick_ls ? ls_addr : if_addr;
          mem_wdata <= pick_ls ? ls_wdata : '0;
        end
        ISSUE: cnt <= CNT_INIT;
        WAIT: begin
          if (cnt == 3'd0) begin
            if (owner_ls) begin
              if (!we_q) ls_rdata <= mem_rdata;
            end else begin
              if_rdata <= mem_rdata;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule
